hist_readout: RTL and testbench

- Downstream consumer of the photon-timing stage; both run on clkin.
- On a host request, snapshots the per-channel photon histogram (NBINS words) and the inter-photon-interval histogram (NIPI words) in a single cycle.
- Streams the snapshot as a framed byte sequence over a valid/ready byte interface toward the host serial/USB bridge.
- Optionally issues the clear pulse (resethist) back to the histogramming stage so counting restarts.

---
 rtl/hist_pkg.sv | 28 ++
 rtl/hist_readout_if.sv | 18 +
 rtl/byte_serializer.sv | 57 +++++
 rtl/hist_readout.sv | 117 +++++++++++
 tb/tb_hist_readout.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hist_pkg.sv
// Shared sizing, framing constants and FSM encoding for the histogram readout block.
package hist_pkg;

  localparam int unsigned NBINS  = 8;
  localparam int unsigned NIPI   = 64;
  localparam int unsigned WORDW  = 32;
  localparam logic [7:0]  HEADER = 8'hA5;

  localparam int unsigned NWORDS = NBINS + NIPI;
  localparam int unsigned BPW    = WORDW / 8;
  localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StSnap = 3'd1;
  localparam state_t StHdr  = 3'd2;
  localparam state_t StLen  = 3'd3;
  localparam state_t StData = 3'd4;
  localparam state_t StCsum = 3'd5;

  // Header + length + payload + checksum.
  function automatic int unsigned frame_bytes();
    return 3 + NWORDS * BPW;
  endfunction

endpackage

// File: rtl/hist_readout_if.sv
// Byte stream toward the host bridge: valid/ready handshake, one byte per accepted cycle.
interface hist_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/byte_serializer.sv
// Holds the histogram snapshot and walks it word by word, least-significant byte first.
module byte_serializer
  import hist_pkg::*;
(
  input  logic                   clkin,
  input  logic                   nrst,
  input  logic                   snap,
  input  logic                   advance,
  input  logic [NBINS*WORDW-1:0] histo_flat,
  input  logic [NIPI*WORDW-1:0]  ipi_flat,
  output logic [7:0]             cur_byte,
  output logic                   last
);

  logic [WORDW-1:0]  snap_mem [NWORDS];
  logic [WIDX_W-1:0] widx_q;
  logic [BIDX_W-1:0] bidx_q;
  logic [WORDW-1:0]  cur_word;
  logic [BIDX_W+2:0] bit_off;

  // Snapshot contents are don't-care out of reset, so no reset term here.
  always_ff @(posedge clkin) begin
    if (snap) begin
      for (int j = 0; j < NBINS; j++) begin
        snap_mem[j] <= histo_flat[j*WORDW +: WORDW];
      end
      for (int k = 0; k < NIPI; k++) begin
        snap_mem[NBINS+k] <= ipi_flat[k*WORDW +: WORDW];
      end
    end
  end

  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      widx_q <= '0;
      bidx_q <= '0;
    end else if (snap) begin
      widx_q <= '0;
      bidx_q <= '0;
    end else if (advance) begin
      if (bidx_q == BIDX_W'(BPW - 1)) begin
        bidx_q <= '0;
        widx_q <= widx_q + 1'b1;
      end else begin
        bidx_q <= bidx_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur_word = snap_mem[widx_q];
    bit_off  = {bidx_q, 3'b000};
    cur_byte = cur_word[bit_off +: 8];
    last     = (widx_q == WIDX_W'(NWORDS - 1)) && (bidx_q == BIDX_W'(BPW - 1));
  end

endmodule

// File: rtl/hist_readout.sv
// Snapshots both histograms on request and streams them as a framed, checksummed byte sequence.
module hist_readout
  import hist_pkg::*;
(
  input  logic                   clkin,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   clear_on_read,
  input  logic [NBINS*WORDW-1:0] histo_flat,
  input  logic [NIPI*WORDW-1:0]  ipi_flat,
  hist_readout_if.master         tx,
  output logic                   resethist,
  output logic                   busy,
  output logic                   done
);

  if (NWORDS > 255) begin : gen_len_check
    $error("hist_readout: NBINS+NIPI must fit in the 8-bit length byte");
  end
  if ((WORDW % 8) != 0) begin : gen_width_check
    $error("hist_readout: WORDW must be a multiple of 8");
  end

  state_t     state_q, state_d;
  logic       clr_q;
  logic       done_q;
  logic [7:0] csum_q;
  logic [7:0] cur_byte;
  logic       last;
  logic       snap;
  logic       advance;
  logic       tx_valid_c;
  logic [7:0] tx_data_c;
  logic       start_ok;

  // The done cycle is already IDLE, but a start there must not open a new frame.
  assign start_ok = (state_q == StIdle) && start && !done_q;
  assign snap     = (state_q == StSnap);

  byte_serializer u_byte_serializer (
    .clkin      (clkin),
    .nrst       (nrst),
    .snap       (snap),
    .advance    (advance),
    .histo_flat (histo_flat),
    .ipi_flat   (ipi_flat),
    .cur_byte   (cur_byte),
    .last       (last)
  );

  always_comb begin
    state_d    = state_q;
    advance    = 1'b0;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StSnap;
      end
      StSnap: begin
        state_d = StHdr;
      end
      StHdr: begin
        tx_valid_c = 1'b1;
        tx_data_c  = HEADER;
        if (tx.tx_ready) state_d = StLen;
      end
      StLen: begin
        tx_valid_c = 1'b1;
        tx_data_c  = 8'(NWORDS);
        if (tx.tx_ready) state_d = StData;
      end
      StData: begin
        tx_valid_c = 1'b1;
        tx_data_c  = cur_byte;
        if (tx.tx_ready) begin
          advance = 1'b1;
          if (last) state_d = StCsum;
        end
      end
      StCsum: begin
        tx_valid_c = 1'b1;
        tx_data_c  = csum_q;
        if (tx.tx_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StCsum) && tx.tx_ready;
      if (start_ok) clr_q <= clear_on_read;
      if (state_q == StSnap) begin
        csum_q <= 8'h00;
      end else if (advance) begin
        csum_q <= csum_q ^ cur_byte;
      end
    end
  end

  assign tx.tx_valid = tx_valid_c;
  assign tx.tx_data  = tx_data_c;
  // Combinational from state so a mid-frame reset drops it without waiting for a clock.
  assign resethist   = snap && clr_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;

endmodule

// File: tb/tb_hist_readout.sv
// Self-checking bench for hist_readout: frames are compared against a byte-level frame model.
module tb_hist_readout;
  import hist_pkg::*;

  logic                   clkin = 1'b0;
  logic                   nrst = 1'b0;
  logic                   start = 1'b0;
  logic                   clear_on_read = 1'b0;
  logic [NBINS*WORDW-1:0] histo_flat = '0;
  logic [NIPI*WORDW-1:0]  ipi_flat = '0;
  logic                   resethist;
  logic                   busy;
  logic                   done;

  hist_readout_if tx_if ();

  hist_readout dut (
    .clkin         (clkin),
    .nrst          (nrst),
    .start         (start),
    .clear_on_read (clear_on_read),
    .histo_flat    (histo_flat),
    .ipi_flat      (ipi_flat),
    .tx            (tx_if),
    .resethist     (resethist),
    .busy          (busy),
    .done          (done)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int done_cnt, rh_cnt, rh_first, first_valid, stall_viol, busy_after;

  // Frame as the host should see it: header, word count, payload LSB-first, XOR of payload.
  function automatic void build_expected();
    logic [WORDW-1:0] w;
    logic [7:0]       b;
    logic [7:0]       csum;
    logic [7:0]       len;
    exp_q.delete();
    len  = 8'(NWORDS);
    csum = 8'h00;
    exp_q.push_back(HEADER);
    exp_q.push_back(len);
    for (int j = 0; j < int'(NWORDS); j++) begin
      if (j < int'(NBINS)) w = histo_flat[j*WORDW +: WORDW];
      else                 w = ipi_flat[(j-int'(NBINS))*WORDW +: WORDW];
      for (int i = 0; i < int'(BPW); i++) begin
        b = w[8*i +: 8];
        exp_q.push_back(b);
        csum = csum ^ b;
      end
    end
    exp_q.push_back(csum);
  endfunction

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int j = 0; j < int'(NBINS); j++) histo_flat[j*WORDW +: WORDW] = WORDW'($urandom);
    for (int k = 0; k < int'(NIPI); k++) ipi_flat[k*WORDW +: WORDW] = WORDW'($urandom);
  endtask

  task automatic set_pattern();
    for (int j = 0; j < int'(NBINS); j++) histo_flat[j*WORDW +: WORDW] = WORDW'(j + 1);
    for (int k = 0; k < int'(NIPI); k++) ipi_flat[k*WORDW +: WORDW] = WORDW'(32'h100 + k);
  endtask

  // Leaves the bench one cycle after start was sampled, i.e. inside the SNAP cycle.
  task automatic do_start(input bit clr);
    start = 1'b1;
    clear_on_read = clr;
    step();
    start = 1'b0;
    clear_on_read = 1'b0;
  endtask

  // Records accepted bytes and side events; cycle 0 is the SNAP cycle.
  task automatic collect(input int ready_pct, input bit churn, input bit spam);
    logic       have_hold;
    logic [7:0] hold;
    int         extra;
    bit         seen;
    got_q.delete();
    done_cnt = 0; rh_cnt = 0; rh_first = -1; first_valid = -1;
    stall_viol = 0; busy_after = 0;
    have_hold = 1'b0; hold = 8'h00; extra = 0; seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done === 1'b1) begin
        done_cnt++;
        seen = 1'b1;
      end
      if (resethist === 1'b1) begin
        rh_cnt++;
        if (rh_first < 0) rh_first = c;
      end
      if (seen && done !== 1'b1) begin
        extra++;
        if (busy !== 1'b0) busy_after++;
      end
      if (spam) start = seen ? done : ($urandom_range(0, 3) == 0);
      if (churn && c > 0) randomize_inputs();
      tx_if.tx_ready = ($urandom_range(0, 99) < ready_pct);
      if (have_hold && !(tx_if.tx_valid === 1'b1 && tx_if.tx_data === hold)) stall_viol++;
      have_hold = tx_if.tx_valid && !tx_if.tx_ready;
      hold = tx_if.tx_data;
      if (tx_if.tx_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready) got_q.push_back(tx_if.tx_data);
      if (extra >= 4) break;
      step();
    end
    tx_if.tx_ready = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    int active;
    tx_if.tx_ready = 1'b1;
    nrst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({tx_if.tx_valid, busy, resethist, done, tx_if.tx_data} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: valid=%b busy=%b rh=%b done=%b data=%h, need all 0",
                 c, tx_if.tx_valid, busy, resethist, done, tx_if.tx_data);
      end
    end
    nrst = 1'b1;
    active = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || resethist !== 1'b0 || done !== 1'b0)
        active++;
    end
    checks++;
    if (active !== 0) begin
      errors++;
      $display("FAIL idle_no_output: %0d active cycles without start, need 0", active);
    end
  endtask

  task automatic test_basic();
    set_pattern();
    build_expected();
    do_start(1'b0);
    checks++;
    if (busy !== 1'b1 || tx_if.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_snap_cycle: busy=%b valid=%b, need busy=1 valid=0", busy, tx_if.tx_valid);
    end
    collect(100, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != int'(frame_bytes())) begin
      errors++;
      $display("FAIL basic_len: got %0d bytes, need %0d", got_q.size(), frame_bytes());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_byte[%0d]: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: %0d done pulses, need 1", done_cnt);
    end
    checks++;
    if (first_valid != 1) begin
      errors++;
      $display("FAIL basic_latency: first valid at cycle %0d after SNAP, need 1", first_valid);
    end
    checks++;
    if (rh_cnt != 0) begin
      errors++;
      $display("FAIL basic_no_clear: resethist high %0d cycles, need 0", rh_cnt);
    end
  endtask

  task automatic test_backpressure();
    set_pattern();
    build_expected();
    do_start(1'b0);
    collect(30, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_len: got %0d bytes, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_byte[%0d]: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d stalled cycles changed data/valid, need 0", stall_viol);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL bp_done: %0d done pulses, need 1", done_cnt);
    end
  endtask

  task automatic test_isolation_clear();
    randomize_inputs();
    build_expected();
    do_start(1'b1);
    collect(100, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL iso_len: got %0d bytes, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL iso_byte[%0d]: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rh_cnt != 1 || rh_first != 0) begin
      errors++;
      $display("FAIL iso_resethist: %0d cycles, first at %0d; need 1 cycle at 0 (SNAP)",
               rh_cnt, rh_first);
    end
  endtask

  task automatic test_start_ignored();
    randomize_inputs();
    build_expected();
    do_start(1'b0);
    collect(100, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ign_len: got %0d bytes, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ign_byte[%0d]: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || busy_after != 0) begin
      errors++;
      $display("FAIL ign_restart: done=%0d busy_after=%0d, need done=1 busy_after=0",
               done_cnt, busy_after);
    end
    randomize_inputs();
    build_expected();
    do_start(1'b0);
    collect(100, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size() || done_cnt != 1) begin
      errors++;
      $display("FAIL ign_second_frame: %0d bytes %0d done, need %0d bytes 1 done",
               got_q.size(), done_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int dcnt;
    randomize_inputs();
    build_expected();
    do_start(1'b0);
    n = 0;
    tx_if.tx_ready = 1'b1;
    for (int c = 0; c < 500 && n < 102; c++) begin
      if (tx_if.tx_valid === 1'b1) n++;
      step();
    end
    checks++;
    if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp_q[102]) begin
      errors++;
      $display("FAIL mid_pre: valid=%b data=%h at byte 100, need valid=1 data=%h",
               tx_if.tx_valid, tx_if.tx_data, exp_q[102]);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || resethist !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: valid=%b busy=%b rh=%b done=%b, need all 0",
               tx_if.tx_valid, busy, resethist, done);
    end
    step();
    step();
    nrst = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done !== 1'b0 || tx_if.tx_valid !== 1'b0) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL mid_no_done: %0d cycles with done/valid after abort, need 0", dcnt);
    end
    randomize_inputs();
    build_expected();
    do_start(1'b0);
    collect(100, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size() || done_cnt != 1) begin
      errors++;
      $display("FAIL mid_recover_len: %0d bytes %0d done, need %0d bytes 1 done",
               got_q.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_recover_byte[%0d]: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    tx_if.tx_ready = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation_clear();
    test_start_ignored();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
